// File: rtl/puc_cpu_pkg.sv
// Shared widths, opcode constants, instruction field positions and the default
// program image for the PucCPU core.
package puc_cpu_pkg;

  localparam int unsigned COUNTER_WIDTH     = 8;
  localparam int unsigned INSTRUCTION_WIDTH = 12;
  localparam int unsigned REGISTER_WIDTH    = 8;

  localparam int unsigned ROM_DEPTH = 2 ** COUNTER_WIDTH;
  localparam int unsigned ROM_BITS  = ROM_DEPTH * INSTRUCTION_WIDTH;

  // Instruction fields: [11:8] opcode, [7:0] immediate.
  localparam int unsigned OPCODE_LSB   = 8;
  localparam int unsigned OPCODE_WIDTH = 4;
  localparam int unsigned IMM_LSB      = 0;
  localparam int unsigned IMM_WIDTH    = 8;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI  = 4'h5;
  localparam logic [OPCODE_WIDTH-1:0] OP_XORI = 4'h6;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVR = 4'h7;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDR = 4'h8;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBR = 4'h9;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 4'hA;
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = 4'hB;

  // Default program; every address not listed holds 0x000 (NOP).
  function automatic logic [ROM_BITS-1:0] default_rom();
    logic [ROM_BITS-1:0] img;
    img = '0;
    img[0*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = 12'h105;  // LDI 5
    img[1*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = 12'h203;  // ADDI 3
    img[2*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = 12'h700;  // MOVR
    img[3*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = 12'h301;  // SUBI 1
    img[4*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = 12'h800;  // ADDR
    img[5*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = 12'h60F;  // XORI 0x0F
    img[6*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = 12'hB00;  // JZ 0
    return img;
  endfunction

  localparam logic [ROM_BITS-1:0] DEFAULT_ROM = default_rom();

endpackage

// File: rtl/puc_cpu_counter.sv
// Program counter: loads a jump target when requested, otherwise increments and
// wraps. The register is named count so a bench can preset it hierarchically.
module puc_cpu_counter
  import puc_cpu_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] loadValue,
  output logic [COUNTER_WIDTH-1:0] count
);

  logic [COUNTER_WIDTH-1:0] count_d;

  // Next address: jump target or sequential (natural wrap at the top).
  always_comb begin
    count_d = count + 1'b1;
    if (load) begin
      count_d = loadValue;
    end
  end

  // Only a clean 1 resets; X/Z on reset falls through to the update.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/puc_cpu.sv
// PucCPU core: program counter, fixed ROM, combinational ALU, accumulator and
// register1. One instruction retires per clock; all state is visible on ports.
module puc_cpu
  import puc_cpu_pkg::*;
#(
  parameter logic [ROM_BITS-1:0] ROM_IMAGE = DEFAULT_ROM
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [COUNTER_WIDTH-1:0]     count,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [REGISTER_WIDTH-1:0]    accumulator,
  output logic [REGISTER_WIDTH-1:0]    register1,
  output logic [REGISTER_WIDTH-1:0]    aluResult
);

  logic [INSTRUCTION_WIDTH-1:0] rom_words [ROM_DEPTH];
  logic [OPCODE_WIDTH-1:0]      opcode;
  logic [IMM_WIDTH-1:0]         imm;
  logic [REGISTER_WIDTH-1:0]    acc_q, acc_d;
  logic [REGISTER_WIDTH-1:0]    reg1_q, reg1_d;
  logic                         acc_we, reg1_we, pc_load;
  logic [COUNTER_WIDTH-1:0]     pc_target;

  // Unpack the flat ROM image into addressable words.
  for (genvar i = 0; i < int'(ROM_DEPTH); i++) begin : g_rom
    assign rom_words[i] = ROM_IMAGE[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
  end

  assign instruction = rom_words[count];
  assign opcode      = instruction[OPCODE_LSB +: OPCODE_WIDTH];
  assign imm         = instruction[IMM_LSB +: IMM_WIDTH];
  assign pc_target   = COUNTER_WIDTH'(imm);

  puc_cpu_counter counter (
    .clock     (clock),
    .reset     (reset),
    .load      (pc_load),
    .loadValue (pc_target),
    .count     (count)
  );

  // ALU and write-enable decode; unused opcodes 0xC-0xF behave as NOP.
  always_comb begin
    aluResult = acc_q;
    acc_we    = 1'b0;
    reg1_we   = 1'b0;
    pc_load   = 1'b0;
    case (opcode)
      OP_LDI:  begin aluResult = imm;           acc_we = 1'b1; end
      OP_ADDI: begin aluResult = acc_q + imm;   acc_we = 1'b1; end
      OP_SUBI: begin aluResult = acc_q - imm;   acc_we = 1'b1; end
      OP_ANDI: begin aluResult = acc_q & imm;   acc_we = 1'b1; end
      OP_ORI:  begin aluResult = acc_q | imm;   acc_we = 1'b1; end
      OP_XORI: begin aluResult = acc_q ^ imm;   acc_we = 1'b1; end
      OP_MOVR: reg1_we = 1'b1;
      OP_ADDR: begin aluResult = acc_q + reg1_q; acc_we = 1'b1; end
      OP_SUBR: begin aluResult = acc_q - reg1_q; acc_we = 1'b1; end
      OP_JMP:  pc_load = 1'b1;
      OP_JZ:   pc_load = (acc_q == '0);
      default: ;
    endcase
  end

  // Register next-state from the decoded write enables.
  always_comb begin
    acc_d  = acc_we ? aluResult : acc_q;
    reg1_d = reg1_we ? acc_q : reg1_q;
  end

  // Architectural registers; reset wins over any instruction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      reg1_q <= '0;
    end else begin
      acc_q  <= acc_d;
      reg1_q <= reg1_d;
    end
  end

  assign accumulator = acc_q;
  assign register1   = reg1_q;

endmodule

// File: tb/tb_puc_cpu.sv
// Bench for puc_cpu: two cores (default program and an exercise program) run in
// lockstep against an instruction-level reference model, with random resets.
module tb_puc_cpu;

  localparam int unsigned ROM_BITS = 256 * 12;

  // Exercise program: wraps, untaken JZ, logic ops, SUBR, reserved opcode,
  // taken JZ, JMP chain and a run of NOPs wrapping from 0xFF to 0x00.
  function automatic logic [ROM_BITS-1:0] build_test_rom();
    logic [ROM_BITS-1:0] img;
    img = '0;
    img[0*12 +: 12]    = 12'h102;  // LDI 2
    img[1*12 +: 12]    = 12'h2FF;  // ADDI 0xFF -> 1
    img[2*12 +: 12]    = 12'h303;  // SUBI 3 -> 0xFE
    img[3*12 +: 12]    = 12'hB10;  // JZ 0x10, not taken
    img[4*12 +: 12]    = 12'h700;  // MOVR
    img[5*12 +: 12]    = 12'h4F0;  // ANDI 0xF0
    img[6*12 +: 12]    = 12'h505;  // ORI 0x05
    img[7*12 +: 12]    = 12'h900;  // SUBR
    img[8*12 +: 12]    = 12'hC33;  // reserved -> NOP
    img[9*12 +: 12]    = 12'h6F7;  // XORI 0xF7 -> 0
    img[10*12 +: 12]   = 12'hB20;  // JZ 0x20, taken
    img[32*12 +: 12]   = 12'hA40;  // JMP 0x40
    img[64*12 +: 12]   = 12'hAF0;  // JMP 0xF0
    return img;
  endfunction

  localparam logic [ROM_BITS-1:0] TEST_ROM = build_test_rom();

  logic       clock = 1'b0;
  logic       reset_a, reset_b;
  logic [7:0] count_a, count_b;
  logic [11:0] instr_a, instr_b;
  logic [7:0] acc_a, acc_b, r1_a, r1_b, alu_a, alu_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 = default program, 1 = exercise program.
  int m_rom [2][256];
  int m_pc  [2];
  int m_acc [2];
  int m_r1  [2];

  int acc_trace [7] = '{5, 8, 8, 7, 15, 0, 0};
  int alu_trace [7] = '{5, 8, 8, 7, 15, 0, 0};

  always #5 clock = ~clock;

  puc_cpu cpu (
    .clock       (clock),
    .reset       (reset_a),
    .count       (count_a),
    .instruction (instr_a),
    .accumulator (acc_a),
    .register1   (r1_a),
    .aluResult   (alu_a)
  );

  puc_cpu #(
    .ROM_IMAGE (TEST_ROM)
  ) cpu_b (
    .clock       (clock),
    .reset       (reset_b),
    .count       (count_b),
    .instruction (instr_b),
    .accumulator (acc_b),
    .register1   (r1_b),
    .aluResult   (alu_b)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Value the ALU should present for the model's current instruction.
  function automatic int model_alu(input int i);
    int word, op, imm;
    word = m_rom[i][m_pc[i]];
    op   = word / 256;
    imm  = word % 256;
    case (op)
      1:       return imm;
      2:       return (m_acc[i] + imm) % 256;
      3:       return (m_acc[i] + 256 - imm) % 256;
      4:       return m_acc[i] & imm;
      5:       return m_acc[i] | imm;
      6:       return m_acc[i] ^ imm;
      8:       return (m_acc[i] + m_r1[i]) % 256;
      9:       return (m_acc[i] + 256 - m_r1[i]) % 256;
      default: return m_acc[i];
    endcase
  endfunction

  // Retire one instruction (or apply reset) in the model.
  task automatic model_edge(input int i, input bit rst);
    int word, op, imm, nxt, alu;
    if (rst) begin
      m_pc[i] = 0; m_acc[i] = 0; m_r1[i] = 0;
      return;
    end
    word = m_rom[i][m_pc[i]];
    op   = word / 256;
    imm  = word % 256;
    alu  = model_alu(i);
    nxt  = (m_pc[i] + 1) % 256;
    if (op inside {[1:6], 8, 9}) m_acc[i] = alu;
    if (op == 7) m_r1[i] = m_acc[i];
    if (op == 10) nxt = imm;
    if (op == 11 && m_acc[i] == 0) nxt = imm;
    m_pc[i] = nxt;
  endtask

  task automatic compare_all();
    check_eq("a.count", int'(count_a), m_pc[0]);
    check_eq("a.instruction", int'(instr_a), m_rom[0][m_pc[0]]);
    check_eq("a.accumulator", int'(acc_a), m_acc[0]);
    check_eq("a.register1", int'(r1_a), m_r1[0]);
    check_eq("a.aluResult", int'(alu_a), model_alu(0));
    check_eq("b.count", int'(count_b), m_pc[1]);
    check_eq("b.instruction", int'(instr_b), m_rom[1][m_pc[1]]);
    check_eq("b.accumulator", int'(acc_b), m_acc[1]);
    check_eq("b.register1", int'(r1_b), m_r1[1]);
    check_eq("b.aluResult", int'(alu_b), model_alu(1));
  endtask

  // Drive resets, take one edge, update the model, compare on the falling edge.
  task automatic cycle(input logic ra, input logic rb);
    reset_a = ra;
    reset_b = rb;
    @(posedge clock);
    model_edge(0, ra === 1'b1);
    model_edge(1, rb === 1'b1);
    @(negedge clock);
    compare_all();
  endtask

  function automatic logic pick_reset();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4) return 1'b1;
    if (r < 8) return 1'bx;
    return 1'b0;
  endfunction

  initial begin
    for (int a = 0; a < 256; a++) begin
      m_rom[0][a] = 0;
      m_rom[1][a] = int'(TEST_ROM[a*12 +: 12]);
    end
    m_rom[0][0] = 'h105; m_rom[0][1] = 'h203; m_rom[0][2] = 'h700;
    m_rom[0][3] = 'h301; m_rom[0][4] = 'h800; m_rom[0][5] = 'h60F;
    m_rom[0][6] = 'hB00;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 0; m_acc[i] = 0; m_r1[i] = 0;
    end
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clock);

    // Reset state.
    cycle(1'b1, 1'b1);
    check_eq("rst.count", int'(count_a), 0);
    check_eq("rst.acc", int'(acc_a), 0);
    check_eq("rst.r1", int'(r1_a), 0);
    check_eq("rst.instruction", int'(instr_a), 'h105);
    check_eq("rst.alu", int'(alu_a), 5);

    // Default program trace over two loop iterations.
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, 1'b0);
      check_eq("trace.acc", int'(acc_a), acc_trace[k % 7]);
      check_eq("trace.alu", int'(alu_a), alu_trace[(k + 1) % 7]);
      check_eq("trace.r1", int'(r1_a), (k >= 2) ? 8 : 0);
      if (k == 0) check_eq("wrap.ldi", int'(acc_b), 2);
      if (k == 1) check_eq("wrap.addi", int'(acc_b), 1);
      if (k == 2) check_eq("wrap.subi", int'(acc_b), 'hFE);
      if (k == 3) check_eq("jz.untaken", int'(count_b), 4);
      if (k == 6) check_eq("loop.count", int'(count_a), 0);
    end

    // Reset on the JZ cycle: registers cleared, jump ignored.
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0);
    check_eq("jzcyc.count_pre", int'(count_a), 6);
    cycle(1'b1, 1'b0);
    check_eq("jzrst.count", int'(count_a), 0);
    check_eq("jzrst.r1", int'(r1_a), 0);
    check_eq("jzrst.acc", int'(acc_a), 0);

    // Run the exercise program long enough to hit JMP and the 0xFF wrap.
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 60; k++) cycle(1'b0, 1'b0);

    // Random resets (including undriven X) against the model.
    for (int k = 0; k < 600; k++) cycle(pick_reset(), pick_reset());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/puc_cpu.md
# puc_cpu

Minimal accumulator CPU with a built-in program ROM: a program counter addresses the ROM, the fetched 12-bit instruction (4-bit opcode, 8-bit immediate) drives a combinational ALU, and one instruction retires per clock. It is the top-level core of the PucCPU design, with all internal state brought out as ports for a display/monitor bench.

## Interface
- COUNTER_WIDTH, 8, program-counter width; ROM depth 2^COUNTER_WIDTH.
- INSTRUCTION_WIDTH, 12, instruction word: [11:8] opcode, [7:0] immediate.
- REGISTER_WIDTH, 8, accumulator/register1/ALU width.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; only a logic 1 counts as asserted.
- count  out  COUNTER_WIDTH  current program-counter value.
- instruction  out  INSTRUCTION_WIDTH  ROM word at address count.
- accumulator  out  REGISTER_WIDTH  accumulator register.
- register1  out  REGISTER_WIDTH  general register 1.
- aluResult  out  REGISTER_WIDTH  combinational ALU output for the current instruction.

## Operation
- instruction = rom[count], combinational; aluResult combinational from opcode, immediate (imm), accumulator, register1.
- Opcodes (arithmetic modulo 2^REGISTER_WIDTH, no flags or carry):
  - 0x0 NOP: aluResult=acc; no writes.
  - 0x1 LDI: aluResult=imm; acc<=aluResult.
  - 0x2 ADDI: acc+imm -> acc. 0x3 SUBI: acc-imm -> acc.
  - 0x4 ANDI, 0x5 ORI, 0x6 XORI: bitwise with imm -> acc.
  - 0x7 MOVR: aluResult=acc; register1<=acc.
  - 0x8 ADDR: acc+register1 -> acc. 0x9 SUBR: acc-register1 -> acc.
  - 0xA JMP: aluResult=acc; count<=imm[COUNTER_WIDTH-1:0].
  - 0xB JZ: aluResult=acc; if acc==0 count<=imm, else count+1.
  - 0xC-0xF: treated as NOP.
- Non-jump instructions: count<=count+1, wrapping from 2^COUNTER_WIDTH-1 to 0.
- ROM contents fixed at elaboration; default program:
  - 0:0x105 LDI 5; 1:0x203 ADDI 3; 2:0x700 MOVR; 3:0x301 SUBI 1; 4:0x800 ADDR; 5:0x60F XORI 0x0F; 6:0xB00 JZ 0.
  - All other addresses 0x000 (NOP).

## Timing
- One instruction per cycle; no pipeline, no stalls.
- Register writes (count, accumulator, register1) take effect on the rising edge that ends the instruction's cycle; instruction/aluResult settle combinationally after.
- Reset (clock edge with reset=1): count=0, accumulator=0, register1=0; overrides any instruction that cycle, including jumps. After reset: instruction=0x105, aluResult=5.
- Reset mid-program: next cycle restarts at address 0 with cleared registers.
- Undriven reset (Z/X): not asserted. The counter register is initialisable hierarchically (cpu.counter.count) by a bench that does not drive reset.
- JZ tests accumulator value before the edge.

## Structure
- Shared package: width parameters, opcode constants (OP_NOP..OP_JZ), field slice positions.
- Sub-module counter (instance name counter): holds register count; inputs clock, reset, load, loadValue; increments otherwise.
- ALU and ROM inline in puc_cpu.

## Test plan
- Reset asserted 1 cycle -> count=0, accumulator=0, register1=0, instruction=0x105, aluResult=5.
- Run default program from 0 -> per cycle accumulator 5, 8, 8, 7, 15, 0; register1=8 from cycle 3; aluResult 5,8,8,7,15,0,0.
- Cycle 7 (JZ 0 with acc=0) -> count returns to 0, loop repeats with identical trace.
- Wrap: ADDI 0xFF on acc=2 -> accumulator=1; SUBI 3 on acc=1 -> 0xFE.
- JZ with acc!=0 -> count increments; JMP 0x40 -> count=0x40; count 0xFF of NOPs -> wraps to 0x00.
- Reset asserted on the JZ cycle -> count=0, registers cleared, jump ignored.
